shift_unit_ctrl: RTL

SHIFT_UNIT_CTRL -- requirements
Module: shift_unit_ctrl

---
 rtl/shift_unit_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shift_unit_ctrl.sv
// rtl/shift_unit_ctrl.sv - four-state shift controller around a left-only barrel shifter
// Define SHIFT_UNIT_SRA_EN to enable op=10 as arithmetic right shift; otherwise op=10 is reserved.

module Shifter (
  input  logic [31:0] dataA,
  input  logic [4:0]  dataB,
  output logic [31:0] dataOut
);
  assign dataOut = dataA << dataB;
endmodule

module shift_unit_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dataIn,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] dataOut,
  output logic [7:0]  opCnt
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
`ifdef SHIFT_UNIT_SRA_EN
  localparam logic [1:0] OP_SRA = 2'b10;
`endif

  state_t      state_q;
  logic [1:0]  op_q;
  logic [4:0]  shamt_q;
  logic [31:0] operand_q;
  logic [31:0] result_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] dout_q;
  logic [7:0]  cnt_q;
`ifdef SHIFT_UNIT_SRA_EN
  logic        sign_q;
`endif

  logic [31:0] shift_out;
  logic [31:0] result_rev;
  logic [31:0] dout_d;
  logic        err_d;

  function automatic logic [31:0] bit_rev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Right shifts reuse the left shifter by reversing the operand on the way in and out.
  Shifter u_shifter (
    .dataA   (operand_q),
    .dataB   (shamt_q),
    .dataOut (shift_out)
  );

  always_comb begin
    result_rev = bit_rev(result_q);
    dout_d     = 32'h0;
    err_d      = 1'b0;
    case (op_q)
      OP_SLL: dout_d = result_q;
      OP_SRL: dout_d = result_rev;
`ifdef SHIFT_UNIT_SRA_EN
      OP_SRA: dout_d = sign_q ? (result_rev | ~(32'hFFFF_FFFF >> shamt_q)) : result_rev;
`endif
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      shamt_q   <= 5'd0;
      operand_q <= 32'h0;
      result_q  <= 32'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= 32'h0;
      cnt_q     <= 8'h0;
`ifdef SHIFT_UNIT_SRA_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_LOAD;
            op_q      <= op;
            shamt_q   <= shamt;
            operand_q <= (op == OP_SLL) ? dataIn : bit_rev(dataIn);
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
`ifdef SHIFT_UNIT_SRA_EN
            sign_q    <= dataIn[31];
`endif
          end
        end
        S_LOAD: begin
          state_q  <= S_SHIFT;
          result_q <= shift_out;
        end
        S_SHIFT: begin
          state_q <= S_DONE;
          dout_q  <= dout_d;
          err_q   <= err_d;
          done_q  <= 1'b1;
          cnt_q   <= cnt_q + 8'd1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign dataOut = dout_q;
  assign opCnt   = cnt_q;
endmodule
